// File: rtl/word_feeder.sv
// FIFO-buffered word source: loads words at any time, streams them on start with
// a valid/ready handshake and an optional idle gap after each accepted word.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | head word presented with data_valid, waiting for data_ready
// GAP    | idle cycles after an accepted word
// DONE   | one-cycle done pulse, then back to IDLE
module word_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int GAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     start,
  output logic [WIDTH-1:0]         data,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [WIDTH-1:0]  last_q;
  logic [GW-1:0]     gap_cnt;
  logic              push, pop, last_word;

  assign full      = (count == (AW+1)'(DEPTH));
  assign level     = count;
  assign push      = wr_en && !full;
  assign pop       = (state == S_STREAM) && data_ready;
  // a same-cycle push keeps the run alive even when the last buffered word leaves
  assign last_word = (count == (AW+1)'(1)) && !push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_q   <= '0;
      gap_cnt  <= '0;
      state    <= S_IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
      if (state != S_GAP) gap_cnt <= GAP_LOAD;
      else                gap_cnt <= gap_cnt - 1'b1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (count != '0) ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        if (pop) begin
          if (last_word)    state_nxt = S_DONE;
          else if (GAP > 0) state_nxt = S_GAP;
          else              state_nxt = S_STREAM;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = (count != '0 || push) ? S_STREAM : S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign data_valid = (state == S_STREAM);
  assign data       = data_valid ? mem[rd_ptr] : last_q;
  assign busy       = (state == S_STREAM) || (state == S_GAP);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_word_feeder.sv
// Directed bench for word_feeder: one GAP=0 instance and one GAP=2 instance
// share all inputs; each step checks hand-computed outputs at the falling edge.
module tb_word_feeder;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, data_ready;
  logic [15:0] wr_data;

  logic        full, overflow, data_valid, busy, done;
  logic [4:0]  level;
  logic [15:0] data;
  logic        full_g, overflow_g, data_valid_g, busy_g, done_g;
  logic [4:0]  level_g;
  logic [15:0] data_g;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  word_feeder #(.WIDTH(16), .DEPTH(16), .GAP(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .overflow(overflow), .level(level), .start(start), .data(data),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done)
  );

  word_feeder #(.WIDTH(16), .DEPTH(16), .GAP(2)) dut_g (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_g),
    .overflow(overflow_g), .level(level_g), .start(start), .data(data_g),
    .data_valid(data_valid_g), .data_ready(data_ready), .busy(busy_g), .done(done_g)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " data"},     32'(data), 32'h0);
    chk({tag, " valid"},    32'(data_valid), 32'h0);
    chk({tag, " busy"},     32'(busy), 32'h0);
    chk({tag, " done"},     32'(done), 32'h0);
    chk({tag, " full"},     32'(full), 32'h0);
    chk({tag, " overflow"}, 32'(overflow), 32'h0);
    chk({tag, " level"},    32'(level), 32'h0);
  endtask

  logic [15:0] tog_d   [8] = '{16'hB1, 16'hB1, 16'hB2, 16'hB2, 16'hB2, 16'hB3, 16'hB4, 16'hB4};
  logic        tog_rdy [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        gap_v   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] gap_d   [7] = '{16'hA1, 16'hA1, 16'hA1, 16'hA2, 16'hA2, 16'hA2, 16'hA3};

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // eight words back to back
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    chk("t1 level loaded", 32'(level), 32'd8);
    start = 1'b1; data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t1 data", 32'(data), 32'(i));
      chk("t1 valid", 32'(data_valid), 32'h1);
      @(negedge clk);
    end
    chk("t1 done", 32'(done), 32'h1);
    chk("t1 valid after", 32'(data_valid), 32'h0);
    chk("t1 data held", 32'(data), 32'h8);
    @(negedge clk);
    chk("t1 done cleared", 32'(done), 32'h0);
    chk("t1 busy idle", 32'(busy), 32'h0);
    chk("t1 level empty", 32'(level), 32'h0);
    data_ready = 1'b0;
    rst_pulse();

    // overflow: 17 pushes into 16 entries
    for (int i = 0; i < 16; i++) push_word(16'h100 + 16'(i));
    chk("t2 full", 32'(full), 32'h1);
    chk("t2 level full", 32'(level), 32'd16);
    chk("t2 no overflow yet", 32'(overflow), 32'h0);
    push_word(16'h1FF);
    chk("t2 overflow set", 32'(overflow), 32'h1);
    chk("t2 level still 16", 32'(level), 32'd16);
    start = 1'b1; data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t2 data", 32'(data), 32'h100 + 32'(i));
      if (i == 1) chk("t2 full after pop", 32'(full), 32'h0);
      @(negedge clk);
    end
    chk("t2 done", 32'(done), 32'h1);
    chk("t2 overflow sticky", 32'(overflow), 32'h1);
    data_ready = 1'b0;
    rst_pulse();
    chk("t2 overflow cleared", 32'(overflow), 32'h0);

    // GAP=2 instance
    push_word(16'hA1); push_word(16'hA2); push_word(16'hA3);
    start = 1'b1; data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("t3 gap valid", 32'(data_valid_g), 32'(gap_v[i]));
      chk("t3 gap data", 32'(data_g), 32'(gap_d[i]));
      chk("t3 gap busy", 32'(busy_g), 32'h1);
      @(negedge clk);
    end
    chk("t3 gap done", 32'(done_g), 32'h1);
    chk("t3 gap valid end", 32'(data_valid_g), 32'h0);
    data_ready = 1'b0;
    rst_pulse();

    // ready toggling
    for (int i = 0; i < 4; i++) push_word(16'hB1 + 16'(i));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4 data", 32'(data), 32'(tog_d[i]));
      chk("t4 valid", 32'(data_valid), 32'h1);
      data_ready = tog_rdy[i];
      @(negedge clk);
    end
    chk("t4 done", 32'(done), 32'h1);
    chk("t4 level", 32'(level), 32'h0);
    data_ready = 1'b0;
    rst_pulse();

    // empty start, then start ignored mid-run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5 empty done", 32'(done), 32'h1);
    chk("t5 empty valid", 32'(data_valid), 32'h0);
    @(negedge clk);
    chk("t5 empty done cleared", 32'(done), 32'h0);
    push_word(16'hC1); push_word(16'hC2);
    start = 1'b1;
    @(negedge clk);
    chk("t5 first word", 32'(data), 32'hC1);
    @(negedge clk);
    start = 1'b0;
    chk("t5 held after restart", 32'(data), 32'hC1);
    chk("t5 level", 32'(level), 32'd2);
    data_ready = 1'b1;
    @(negedge clk);
    chk("t5 second word", 32'(data), 32'hC2);
    @(negedge clk);
    chk("t5 done", 32'(done), 32'h1);
    @(negedge clk);
    chk("t5 idle", 32'(busy), 32'h0);
    chk("t5 no rerun", 32'(data_valid), 32'h0);
    data_ready = 1'b0;
    rst_pulse();

    // reset mid-run after three of six words
    for (int i = 0; i < 6; i++) push_word(16'hD1 + 16'(i));
    start = 1'b1; data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6 data", 32'(data), 32'hD1 + 32'(i));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("t6 abort");
    @(negedge clk);
    chk("t6 no done", 32'(done), 32'h0);
    push_word(16'hE1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6 restart data", 32'(data), 32'hE1);
    wr_en = 1'b1; wr_data = 16'hE2;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t6 joined data", 32'(data), 32'hE2);
    chk("t6 joined valid", 32'(data_valid), 32'h1);
    chk("t6 push+pop level", 32'(level), 32'd1);
    @(negedge clk);
    chk("t6 done", 32'(done), 32'h1);
    chk("t6 level end", 32'(level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/word_feeder.md
# word_feeder

Buffered source stage that sits directly upstream of the 16-bit `interface` data input. Software or a loader pushes words into an internal FIFO. On a start pulse, the block streams the buffered words out one at a time with a valid/ready handshake and an optional idle gap between words. It flags completion when the FIFO drains and flags any overflow on the load side.

## Interface
- `WIDTH`, 16, data word width in bits.
- `DEPTH`, 16, FIFO depth in words; must be a power of 2 and at least 2.
- `GAP`, 0, idle cycles inserted after each accepted word (0 means back-to-back).
- `clk`  in  1  single clock; all logic samples on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `wr_en`  in  1  push `wr_data` into the FIFO this cycle.
- `wr_data`  in  WIDTH  word to push.
- `full`  out  1  FIFO holds DEPTH words.
- `overflow`  out  1  sticky; set when `wr_en` is high while `full`. Cleared only by `rst`.
- `level`  out  $clog2(DEPTH)+1  number of words currently held.
- `start`  in  1  one-cycle request to begin streaming.
- `data`  out  WIDTH  word presented to the downstream `interface` `data` input.
- `data_valid`  out  1  `data` holds a word to transfer.
- `data_ready`  in  1  downstream accepts `data` this cycle.
- `busy`  out  1  high in STREAM and GAP.
- `done`  out  1  one-cycle pulse when a run ends.

## Operation
- Reset values: FIFO emptied, state IDLE, `data`=0, `data_valid`=0, `busy`=0, `done`=0, `full`=0, `overflow`=0, `level`=0.
- Push rules:
  - `wr_en && !full` stores `wr_data` at the tail.
  - `wr_en && full` drops the word and sets `overflow`.
  - Pushes are accepted in every state.
- Pop: occurs on any cycle with `data_valid && data_ready`. A push and a pop in the same cycle leave `level` unchanged, and both take effect.
- FSM states are IDLE, STREAM, GAP, DONE.
  - IDLE: `start` with `level`>0 goes to STREAM. `start` with `level`=0 goes to DONE.
  - STREAM: `data_valid`=1 and `data` = FIFO head. Both are held stable until `data_ready`.
    - On a transfer where the FIFO becomes empty (counting a same-cycle push): go to DONE.
    - On a transfer where words remain and GAP>0: go to GAP.
    - On a transfer where words remain and GAP=0: stay in STREAM and present the next word the following cycle.
  - GAP: `data_valid`=0 for exactly GAP cycles, then return to STREAM. If the FIFO is empty at that point, go to DONE instead.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- `start` is ignored outside IDLE.
- Words pushed during a run join that run if they arrive before the FIFO empties.
- `data` keeps its last transferred value while `data_valid`=0.
- Pointers wrap modulo DEPTH; `level` ranges 0..DEPTH.
- `rst` mid-run aborts immediately: no `done` pulse and all contents are discarded.

## Timing
- `start` sampled at edge N: `data_valid`=1 with the head word from cycle N+1.
- Empty start at edge N: `done`=1 during cycle N+1 and `data_valid` stays 0.
- GAP=0 with `data_ready` held high: one word per cycle, with no bubbles.
- GAP=g: g+1 cycles per word when `data_ready` is always high.
- Last transfer at edge M: `data_valid`=0 and `done`=1 in cycle M+1; IDLE and `busy`=0 from M+2.
- `full`, `level` and `overflow` are registered and reflect pushes and pops from the previous edge.
- Throughput is never limited by same-cycle push and pop.

## Test plan
- Reset, push 0x0001..0x0008, start, `data_ready`=1, GAP=0 -> `data` = 0x0001..0x0008 on consecutive cycles; `done` pulses one cycle after 0x0008; `level`=0.
- Push 17 words with DEPTH=16 -> `full`=1 after 16 words; 17th word dropped; `overflow`=1 and stays set; streaming yields exactly the first 16 words.
- GAP=2, push 3 words, start -> `data_valid` pattern 1,0,0,1,0,0,1, then `done`.
- Toggle `data_ready` 0/1 during a run -> `data` stable while not ready; no word lost or duplicated; order preserved.
- Start with empty FIFO -> `done` pulse next cycle, no `data_valid`; a second `start` during STREAM is ignored.
- Assert `rst` mid-run after 3 of 6 words -> next cycle all outputs at reset values, `level`=0, no `done`; a fresh push and start works normally.
